// File: rtl/mul8_nibble_seq.sv
// Sequential 8x8 unsigned multiply/accumulate built around one shared
// 4x4 array multiplier core, stepped over four nibble partial products.
module mul8_nibble_seq #(
  parameter int W_ACC = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      product,
  output logic [W_ACC-1:0] acc,
  output logic             busy
);

  if (W_ACC < 16) begin : g_w_acc_chk
    $error("mul8_nibble_seq: W_ACC must be at least 16");
  end

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  step;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic        en_q;
  logic [15:0] psum;
  logic [15:0] psum_nxt;
  logic [3:0]  core_a;
  logic [3:0]  core_b;
  logic [7:0]  pp;
  logic [15:0] pp_sh;

  // Operand-register mux only; external a/b never reach the core.
  always_comb begin
    core_a = a_q[3:0];
    core_b = b_q[3:0];
    pp_sh  = '0;
    unique case (step)
      2'd0: begin
        pp_sh = {8'b0, pp};
      end
      2'd1: begin
        core_a = a_q[7:4];
        pp_sh  = {4'b0, pp, 4'b0};
      end
      2'd2: begin
        core_b = b_q[7:4];
        pp_sh  = {4'b0, pp, 4'b0};
      end
      default: begin
        core_a = a_q[7:4];
        core_b = b_q[7:4];
        pp_sh  = {pp, 8'b0};
      end
    endcase
  end

  // 4x4 array core: sum of shifted AND rows.
  always_comb begin
    pp = '0;
    for (int i = 0; i < 4; i++) begin
      if (core_b[i]) begin
        pp = pp + ({4'b0, core_a} << i);
      end
    end
  end

  assign psum_nxt = psum + pp_sh;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = MUL;
      MUL:  if (step == 2'd3) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      step    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      en_q    <= 1'b0;
      psum    <= '0;
      product <= '0;
      acc     <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q  <= a;
            b_q  <= b;
            en_q <= acc_en;
            psum <= '0;
            step <= '0;
          end
        end
        MUL: begin
          psum <= psum_nxt;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            product <= psum_nxt;
            acc     <= en_q ? acc + W_ACC'(psum_nxt)
                            : W_ACC'(psum_nxt);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul8_nibble_seq.sv
// Randomized bench for mul8_nibble_seq; two instances (W_ACC 20 and 16)
// share stimulus and are checked against a plain arithmetic model.
module tb_mul8_nibble_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready16;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        acc_en;
  logic        out_valid;
  logic        out_valid16;
  logic        out_ready;
  logic [15:0] product;
  logic [15:0] product16;
  logic [19:0] acc;
  logic [15:0] acc16;
  logic        busy;
  logic        busy16;

  int n_chk  = 0;
  int n_pass = 0;
  int n_acc  = 0;
  int cyc    = 0;
  int t_acc  = 0;
  int t_prev = 0;
  int unsigned m_acc20;
  int unsigned m_acc16;

  mul8_nibble_seq #(.W_ACC(20)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .acc_en(acc_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .acc(acc), .busy(busy)
  );

  mul8_nibble_seq #(.W_ACC(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready16),
    .a(a), .b(b), .acc_en(acc_en),
    .out_valid(out_valid16), .out_ready(out_ready),
    .product(product16), .acc(acc16), .busy(busy16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) begin
      n_acc  = n_acc + 1;
      t_prev = t_acc;
      t_acc  = cyc;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called and returns at a negedge with the DUT in IDLE.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb,
                       input logic ten, input int gap, input int stall);
    int k;
    int n0;
    logic [15:0] p_exp;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (gap) begin
      a = 8'($urandom);
      b = 8'($urandom);
      @(negedge clk);
    end
    a = ta; b = tb; acc_en = ten; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    a         = 8'($urandom);
    b         = 8'($urandom);
    out_ready = (stall == 0);
    chk("mul_busy", {busy, in_ready, busy16}, {1'b1, 1'b0, 1'b1});
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'd4);
    p_exp   = 16'(ta) * 16'(tb);
    m_acc20 = ((ten ? m_acc20 : 0) + p_exp) & 32'hF_FFFF;
    m_acc16 = ((ten ? m_acc16 : 0) + p_exp) & 32'hFFFF;
    chk("product", 32'(product), 32'(p_exp));
    chk("acc20", 32'(acc), m_acc20);
    chk("product16", 32'(product16), 32'(p_exp));
    chk("acc16", 32'(acc16), m_acc16);
    n0 = n_acc;
    repeat (stall) begin
      in_valid = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      @(negedge clk);
      chk("bp_ctl", {out_valid, in_ready}, {1'b1, 1'b0});
      chk("bp_product", 32'(product), 32'(p_exp));
      chk("bp_acc", 32'(acc), m_acc20);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    chk("no_capture", 32'(n_acc), 32'(n0));
    chk("post_hs", {out_valid, in_ready}, {1'b0, 1'b1});
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; acc_en = 1'b0;
    m_acc20 = 0; m_acc16 = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ctl", {in_ready, out_valid, busy}, 3'b000);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 32'(in_ready), 32'd1);

    do_op(8'hFF, 8'hFF, 1'b0, 0, 0);
    chk("ff_ff", 32'(acc), 32'h0FE01);
    do_op(8'h12, 8'h34, 1'b0, 1, 0);
    do_op(8'h10, 8'h10, 1'b1, 0, 0);
    chk("interval", 32'(t_acc - t_prev), 32'd6);
    chk("acc_sum", 32'(acc), 32'h004A8);

    do_op(8'hA5, 8'h5A, 1'b0, 0, 10);
    do_op(8'hFF, 8'hFF, 1'b0, 0, 0);
    do_op(8'hFF, 8'hFF, 1'b1, 0, 0);
    chk("wrap16", 32'(acc16), 32'hFC02);

    a = 8'h9C; b = 8'h77; acc_en = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ctl", {busy, out_valid, in_ready}, 3'b000);
    chk("midrst_product", 32'(product), 32'd0);
    chk("midrst_acc", {12'(acc), 20'(acc16)}, 32'd0);
    rst = 1'b0;
    m_acc20 = 0; m_acc16 = 0;
    @(negedge clk);
    do_op(8'h0F, 8'h0F, 1'b0, 0, 0);
    chk("after_rst", 32'(product), 32'h00E1);

    for (int i = 0; i < 1000; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
